uart_rx_frame: RTL

// Oversampling UART receiver. It deserialises the FTDI serial_rxd line into bytes and is the

---
 rtl/uart_rx_frame_if.sv | 11 +
 rtl/uart_rx_frame.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_if.sv
// Byte delivery channel between the UART receiver and its consumer.
interface uart_rx_frame_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: 4 ticks per bit, majority vote of phases 1..3,
// framing/parity/break/overrun reporting, one-entry valid/ready holding register.
module uart_rx_frame #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned SYNC_LEN  = 2
) (
    input  logic            clk_48,
    input  logic            reset,
    input  logic            baud_x4_i,
    input  logic            serial_i,
    uart_rx_frame_if.master byte_if,
    output logic            framing_error_o,
    output logic            parity_error_o,
    output logic            break_det_o,
    output logic            overrun_o,
    input  logic            clear_err_i
);
    localparam int unsigned CNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BRKWAIT
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_LEN-1:0]  sync_q;
    logic [1:0]           phase_q, phase_d;
    logic [1:0]           ones_q, ones_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 brk_q, brk_d;

    logic line_c;
    logic vote_c;
    logic exp_par_c;
    logic deliver_c;
    logic take_c;
    logic overrun_set_c;

    assign line_c    = sync_q[SYNC_LEN-1];
    // Two of three samples high; the third sample is the current line value.
    assign vote_c    = (ones_q == 2'd2) || ((ones_q == 2'd1) && line_c);
    assign exp_par_c = (PARITY == 2) ? ~(^shift_q) : (^shift_q);
    assign take_c    = valid_q && byte_if.ready;

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk_48) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sync_q    <= '1;
            phase_q   <= 2'd0;
            ones_q    <= 2'd0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[SYNC_LEN-2:0], serial_i};
            phase_q   <= phase_d;
            ones_q    <= ones_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            brk_q     <= brk_d;
        end
    end

    // Next-state: tick-driven frame FSM plus the always-running output handshake.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        ones_d        = ones_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_err_d     = par_err_q;
        data_d        = data_q;
        valid_d       = valid_q;
        overrun_d     = overrun_q;
        fe_d          = 1'b0;
        pe_d          = 1'b0;
        brk_d         = 1'b0;
        deliver_c     = 1'b0;
        overrun_set_c = 1'b0;

        if (baud_x4_i) begin
            if (state_q == ST_IDLE) begin
                // This tick is phase 0 of the start bit.
                if (!line_c) begin
                    state_d = ST_START;
                    phase_d = 2'd1;
                    ones_d  = 2'd0;
                end
            end else if (state_q == ST_BRKWAIT) begin
                if (line_c) begin
                    state_d = ST_IDLE;
                end
            end else begin
                phase_d = phase_q + 2'd1;
                if ((phase_q == 2'd1) || (phase_q == 2'd2)) begin
                    ones_d = ones_q + {1'b0, line_c};
                end else if (phase_q == 2'd3) begin
                    ones_d = 2'd0;
                    case (state_q)
                        ST_START: begin
                            if (vote_c) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d   = ST_DATA;
                                bit_cnt_d = '0;
                                par_err_d = 1'b0;
                            end
                        end
                        ST_DATA: begin
                            shift_d   = {vote_c, shift_q[DATA_BITS-1:1]};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                                state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                            end
                        end
                        ST_PARITY: begin
                            par_err_d = (vote_c != exp_par_c);
                            state_d   = ST_STOP;
                        end
                        ST_STOP: begin
                            state_d = ST_IDLE;
                            if (!vote_c) begin
                                if (shift_q == '0) begin
                                    brk_d   = 1'b1;
                                    state_d = ST_BRKWAIT;
                                end else begin
                                    fe_d = 1'b1;
                                end
                            end else if (par_err_q) begin
                                pe_d = 1'b1;
                            end else begin
                                deliver_c = 1'b1;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        end

        if (deliver_c) begin
            if (!valid_q || take_c) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_set_c = 1'b1;
            end
        end else if (take_c) begin
            valid_d = 1'b0;
        end

        if (overrun_set_c) begin
            overrun_d = 1'b1;
        end else if (clear_err_i) begin
            overrun_d = 1'b0;
        end
    end

    assign byte_if.data    = data_q;
    assign byte_if.valid   = valid_q;
    assign framing_error_o = fe_q;
    assign parity_error_o  = pe_q;
    assign break_det_o     = brk_q;
    assign overrun_o       = overrun_q;
endmodule
